// File: rtl/phase_sequencer_if.sv
// Front-panel / datapath bundle for phase_sequencer: run-control inputs in,
// phase strobes and status out. The sequencer itself connects through the slave modport.
interface phase_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              exec_i;
    logic              step_i;
    logic              halt_req_i;
    logic [ADDR_W-1:0] pc_i;
    logic [ADDR_W-1:0] bp_addr_i;
    logic              bp_valid_i;
    logic [4:0]        phase_o;
    logic              pc_en_o;
    logic              running_o;
    logic              halted_o;
    logic              bp_hit_o;
    logic [CNT_W-1:0]  instr_count_o;

    modport master (
        output exec_i, step_i, halt_req_i, pc_i, bp_addr_i, bp_valid_i,
        input  phase_o, pc_en_o, running_o, halted_o, bp_hit_o, instr_count_o
    );

    modport slave (
        input  exec_i, step_i, halt_req_i, pc_i, bp_addr_i, bp_valid_i,
        output phase_o, pc_en_o, running_o, halted_o, bp_hit_o, instr_count_o
    );
endinterface

// File: rtl/phase_sequencer.sv
// Run/stop/step/halt sequencer issuing one-hot P1..P5 phase strobes for the CPU datapath.
// Optional PC breakpoint stop is compiled in when PHASE_SEQ_BREAKPOINT_EN is defined.
module phase_sequencer #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    phase_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_STEP} state_t;

    localparam logic [4:0] P1 = 5'b00001;
    localparam logic [4:0] P4 = 5'b01000;
    localparam logic [4:0] P5 = 5'b10000;

    state_t           state_q, state_d;
    logic [4:0]       phase_q, phase_d;
    logic             pc_en_q, pc_en_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halt_pend_q, halt_pend_d;
    logic             halted_q, halted_d;
    logic             exec_q, step_q;
    logic             armed_q;
    logic             exec_edge, step_edge;
    logic             start;
    logic             halt_now;
    logic [ADDR_W-1:0] bp_addr_w;

    assign bp_addr_w = bus.bp_addr_i;

    // armed_q masks the first clock after reset so a level held through reset is not an edge.
    assign exec_edge = armed_q & bus.exec_i & ~exec_q;
    assign step_edge = armed_q & bus.step_i & ~step_q;

`ifdef PHASE_SEQ_BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;
    logic first_q, first_d;
    logic bp_match;
    assign bp_match = bus.bp_valid_i && (bus.pc_i == bp_addr_w);
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr_w, bus.pc_i, bus.bp_valid_i};
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pc_en_d     = 1'b0;
        count_d     = count_q;
        halt_pend_d = halt_pend_q;
        halted_d    = halted_q;
        start       = 1'b0;
        halt_now    = 1'b0;
`ifdef PHASE_SEQ_BREAKPOINT_EN
        bp_hit_d    = bp_hit_q;
        first_d     = first_q;
`endif
        case (state_q)
            S_IDLE: begin
                phase_d     = '0;
                halt_pend_d = 1'b0;
                if (exec_edge) begin
                    state_d = S_RUN;
                    start   = 1'b1;
                end else if (step_edge) begin
                    state_d = S_STEP;
                    start   = 1'b1;
                end
                if (start) begin
                    phase_d  = P1;
                    halted_d = 1'b0;
`ifdef PHASE_SEQ_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
                    first_d  = 1'b1;
`endif
                end
            end
            default: begin
                if ((phase_q[4:1] != 4'b0000) && bus.halt_req_i)
                    halt_pend_d = 1'b1;
                if (state_q == S_RUN && exec_edge)
                    state_d = S_DRAIN;
                if (phase_q == P5) begin
                    // HALT first seen in P5 still stops, but the P5 pc_en is already out.
                    halt_now    = halt_pend_q | bus.halt_req_i;
                    halt_pend_d = 1'b0;
                    if (halt_now) begin
                        state_d  = S_IDLE;
                        phase_d  = '0;
                        halted_d = 1'b1;
                    end else if (state_q != S_RUN || exec_edge) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = P1;
                    end
                end else begin
                    phase_d = phase_q << 1;
                    if (phase_q == P4) begin
                        count_d = count_q + CNT_W'(1);
                        pc_en_d = ~(halt_pend_q | bus.halt_req_i);
                    end
                end
`ifdef PHASE_SEQ_BREAKPOINT_EN
                if (phase_q == P1) begin
                    first_d = 1'b0;
                    if (!first_q && state_q != S_STEP && bp_match) begin
                        state_d     = S_IDLE;
                        phase_d     = '0;
                        halt_pend_d = 1'b0;
                        bp_hit_d    = 1'b1;
                    end
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            pc_en_q     <= 1'b0;
            count_q     <= '0;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
            exec_q      <= 1'b0;
            step_q      <= 1'b0;
            armed_q     <= 1'b0;
`ifdef PHASE_SEQ_BREAKPOINT_EN
            bp_hit_q    <= 1'b0;
            first_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pc_en_q     <= pc_en_d;
            count_q     <= count_d;
            halt_pend_q <= halt_pend_d;
            halted_q    <= halted_d;
            exec_q      <= bus.exec_i;
            step_q      <= bus.step_i;
            armed_q     <= 1'b1;
`ifdef PHASE_SEQ_BREAKPOINT_EN
            bp_hit_q    <= bp_hit_d;
            first_q     <= first_d;
`endif
        end
    end

    assign bus.phase_o       = phase_q;
    assign bus.pc_en_o       = pc_en_q;
    assign bus.running_o     = (state_q != S_IDLE);
    assign bus.halted_o      = halted_q;
    assign bus.instr_count_o = count_q;
`ifdef PHASE_SEQ_BREAKPOINT_EN
    assign bus.bp_hit_o      = bp_hit_q;
`else
    assign bus.bp_hit_o      = 1'b0;
`endif
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: vector table for run/step/halt/stop sequences,
// plus hand sequences for counter wrap, async reset mid-instruction and reset release.
module tb_phase_sequencer;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    phase_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    phase_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic       exec;
        logic       step;
        logic       halt;
        logic [4:0] phase;
        logic       pc_en;
        logic       running;
        logic       halted;
        logic [7:0] count;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic e, input logic s, input logic h,
                                input logic [4:0] ph, input logic pe, input logic run,
                                input logic hlt, input logic [7:0] cnt);
        vec_t v;
        v.exec = e; v.step = s; v.halt = h; v.phase = ph; v.pc_en = pe;
        v.running = run; v.halted = hlt; v.count = cnt;
        vt.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs();
        return {15'b0, bus.phase_o, bus.pc_en_o, bus.running_o, bus.halted_o,
                bus.bp_hit_o, bus.instr_count_o};
    endfunction

    int pulses;
    logic [ADDR_W-1:0] pc_model;

    initial begin
        bus.exec_i = 0; bus.step_i = 0; bus.halt_req_i = 0;
        bus.pc_i = '0; bus.bp_addr_i = '0; bus.bp_valid_i = 0;

        // exec, step, halt -> phase, pc_en, running, halted, count (state after the edge)
        add(0,0,0, 5'd0, 0,0,0, 8'd0);   // arming clock
        add(0,0,0, 5'd0, 0,0,0, 8'd0);
        add(1,0,0, 5'd1, 0,1,0, 8'd0);   // exec edge -> P1
        add(0,0,0, 5'd2, 0,1,0, 8'd0);
        add(0,0,0, 5'd4, 0,1,0, 8'd0);
        add(0,0,0, 5'd8, 0,1,0, 8'd0);
        add(0,0,0, 5'd16,1,1,0, 8'd1);
        add(0,0,0, 5'd1, 0,1,0, 8'd1);
        add(0,0,0, 5'd2, 0,1,0, 8'd1);
        add(0,0,0, 5'd4, 0,1,0, 8'd1);
        add(1,0,0, 5'd8, 0,1,0, 8'd1);   // stop request during P3
        add(0,0,0, 5'd16,1,1,0, 8'd2);
        add(0,0,0, 5'd0, 0,0,0, 8'd2);
        add(0,0,0, 5'd0, 0,0,0, 8'd2);
        add(0,1,0, 5'd1, 0,1,0, 8'd2);   // single step
        add(0,0,0, 5'd2, 0,1,0, 8'd2);
        add(0,1,0, 5'd4, 0,1,0, 8'd2);   // step during STEP ignored
        add(0,0,0, 5'd8, 0,1,0, 8'd2);
        add(0,0,0, 5'd16,1,1,0, 8'd3);
        add(0,0,0, 5'd0, 0,0,0, 8'd3);
        add(0,0,0, 5'd0, 0,0,0, 8'd3);
        add(1,0,0, 5'd1, 0,1,0, 8'd3);   // run, halt in 2nd instruction
        add(0,0,0, 5'd2, 0,1,0, 8'd3);
        add(0,0,0, 5'd4, 0,1,0, 8'd3);
        add(0,0,0, 5'd8, 0,1,0, 8'd3);
        add(0,0,0, 5'd16,1,1,0, 8'd4);
        add(0,0,0, 5'd1, 0,1,0, 8'd4);
        add(0,0,0, 5'd2, 0,1,0, 8'd4);
        add(0,0,0, 5'd4, 0,1,0, 8'd4);
        add(0,0,1, 5'd8, 0,1,0, 8'd4);   // halt_req in P3
        add(0,0,0, 5'd16,0,1,0, 8'd5);   // P5 without pc_en
        add(0,0,0, 5'd0, 0,0,1, 8'd5);
        add(0,0,0, 5'd0, 0,0,1, 8'd5);
        add(1,0,0, 5'd1, 0,1,0, 8'd5);   // exec clears halted
        add(0,0,0, 5'd2, 0,1,0, 8'd5);
        add(1,0,0, 5'd4, 0,1,0, 8'd5);
        add(0,0,0, 5'd8, 0,1,0, 8'd5);
        add(0,0,0, 5'd16,1,1,0, 8'd6);
        add(0,0,0, 5'd0, 0,0,0, 8'd6);
        add(1,1,0, 5'd1, 0,1,0, 8'd6);   // exec+step together -> RUN
        add(0,0,0, 5'd2, 0,1,0, 8'd6);
        add(0,0,0, 5'd4, 0,1,0, 8'd6);
        add(0,0,0, 5'd8, 0,1,0, 8'd6);
        add(0,0,0, 5'd16,1,1,0, 8'd7);
        add(0,0,0, 5'd1, 0,1,0, 8'd7);   // continues, so it was RUN not STEP
        add(1,0,0, 5'd2, 0,1,0, 8'd7);
        add(0,0,0, 5'd4, 0,1,0, 8'd7);
        add(0,0,0, 5'd8, 0,1,0, 8'd7);
        add(0,0,0, 5'd16,1,1,0, 8'd8);
        add(0,0,0, 5'd0, 0,0,0, 8'd8);

        rst_n = 0;
        tick();
        tick();
        check("reset_state", obs(), 32'd0);
        rst_n = 1;

        foreach (vt[i]) begin
            bus.exec_i = vt[i].exec;
            bus.step_i = vt[i].step;
            bus.halt_req_i = vt[i].halt;
            tick();
            $display("vec %0d exec=%b step=%b halt=%b -> phase=%b pc_en=%b running=%b halted=%b count=%0d",
                     i, vt[i].exec, vt[i].step, vt[i].halt, bus.phase_o, bus.pc_en_o,
                     bus.running_o, bus.halted_o, bus.instr_count_o);
            check($sformatf("vec%0d", i), obs(),
                  {15'b0, vt[i].phase, vt[i].pc_en, vt[i].running, vt[i].halted, 1'b0, vt[i].count});
        end
        bus.exec_i = 0; bus.step_i = 0; bus.halt_req_i = 0;

        // Counter wrap: 8 -> 0 after 248 more instructions; exec during last P5 stops.
        pulses = 0;
        bus.exec_i = 1;
        tick();
        bus.exec_i = 0;
        for (int k = 1; k <= 248; k++) begin
            for (int t = 0; t < 4; t++) tick();
            if (bus.pc_en_o) pulses++;
            if (k == 247) check("count_ff", 32'(bus.instr_count_o), 32'hFF);
            if (k == 248) check("count_wrap", 32'(bus.instr_count_o), 32'h0);
            if (k < 248) tick();
        end
        check("wrap_pc_en_pulses", 32'(pulses), 32'd248);
        $display("wrap run: %0d pc_en pulses, count=%0d", pulses, bus.instr_count_o);
        bus.exec_i = 1;
        tick();
        bus.exec_i = 0;
        check("exec_in_p5_stop", {30'b0, bus.phase_o != 5'd0, bus.running_o}, 32'd0);

        // Async reset in P4 of the second instruction.
        tick();
        bus.exec_i = 1;
        tick();
        bus.exec_i = 0;
        for (int t = 0; t < 8; t++) tick();
        check("pre_reset_p4", {27'b0, bus.phase_o}, 32'd8);
        check("pre_reset_count", 32'(bus.instr_count_o), 32'd1);
        #2 rst_n = 0;
        #1;
        $display("reset in P4: phase=%b count=%0d", bus.phase_o, bus.instr_count_o);
        check("async_reset", obs(), 32'd0);

        // exec held high through reset release must not start a run.
        bus.exec_i = 1;
        tick();
        rst_n = 1;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("exec_held_idle", {26'b0, bus.phase_o, bus.running_o}, 32'd0);
        end
        bus.exec_i = 0;
        tick();
        bus.exec_i = 1;
        tick();
        bus.exec_i = 0;
        check("exec_after_release", {26'b0, bus.phase_o, bus.running_o}, {26'b0, 5'd1, 1'b1});
        $display("exec held across reset: restart phase=%b", bus.phase_o);

`ifdef PHASE_SEQ_BREAKPOINT_EN
        rst_n = 0;
        tick();
        rst_n = 1;
        pc_model = '0;
        bus.pc_i = pc_model;
        bus.bp_addr_i = 16'h0003;
        bus.bp_valid_i = 1;
        tick();
        bus.exec_i = 1;
        tick();
        bus.exec_i = 0;
        for (int t = 0; t < 40 && bus.running_o; t++) begin
            tick();
            if (bus.pc_en_o) pc_model = pc_model + 1'b1;
            bus.pc_i = pc_model;
        end
        $display("breakpoint stop: pc=%0d count=%0d bp_hit=%b", pc_model, bus.instr_count_o, bus.bp_hit_o);
        check("bp_stop", {bus.phase_o, bus.running_o, bus.bp_hit_o, bus.instr_count_o},
              {5'd0, 1'b0, 1'b1, 8'd3});
        check("bp_pc", 32'(pc_model), 32'd3);
        bus.exec_i = 1;
        tick();
        bus.exec_i = 0;
        for (int t = 0; t < 20 && bus.instr_count_o != 8'd4; t++) begin
            tick();
            if (bus.pc_en_o) pc_model = pc_model + 1'b1;
            bus.pc_i = pc_model;
        end
        tick();
        check("bp_resume", {bus.running_o, bus.bp_hit_o, bus.instr_count_o}, {1'b1, 1'b0, 8'd4});
        $display("breakpoint resume: pc=%0d count=%0d", pc_model, bus.instr_count_o);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
